// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with valid/ready handshake, stall, flush and skid.
// Decodes the held instruction into R/I/J fields, immediates and jump target.
module if_id_stage_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter bit          SKID_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc_4,
  input  logic [31:0]     if_instr,
  input  logic            stall,
  input  logic            flush,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc_4,
  output logic [31:0]     id_instr,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [31:0]     imm_sext,
  output logic [31:0]     imm_zext,
  output logic [PC_W-1:0] jmp_target
);

  typedef struct packed {
    logic [PC_W-1:0] pc_4;
    logic [31:0]     instr;
  } if_id_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  if_id_t main_q;
  if_id_t main_d;
  if_id_t skid_q;
  if_id_t skid_d;
  if_id_t in_beat;
  if_id_t nop_beat;
  logic   main_v_q;
  logic   main_v_d;
  logic   skid_v_q;
  logic   skid_v_d;
  logic   acc;
  state_t state;

  assign in_beat  = '{pc_4: if_pc_4, instr: if_instr};
  assign nop_beat = '{pc_4: '0, instr: NOP_INSTR};

  // The skid bit is only ever set while main is valid.
  always_comb begin
    state = FULL;
    if (!main_v_q)
      state = EMPTY;
    else if (skid_v_q)
      state = SKID;
  end

  generate
    if (SKID_EN) begin : g_skid_ready
      assign if_ready = !rst && (state != SKID);
    end else begin : g_comb_ready
      assign if_ready = !rst && (!main_v_q || !stall);
    end
  endgenerate

  assign acc = if_valid && if_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_d   = nop_beat;
      main_v_d = 1'b0;
      skid_d   = nop_beat;
      skid_v_d = 1'b0;
    end else begin
      unique case (1'b1)
        state == EMPTY: begin
          if (acc) begin
            main_d   = in_beat;
            main_v_d = 1'b1;
          end
        end
        state == FULL && !stall: begin
          if (acc) begin
            main_d = in_beat;
          end else begin
            main_d   = nop_beat;
            main_v_d = 1'b0;
          end
        end
        state == FULL && stall: begin
          if (acc && SKID_EN) begin
            skid_d   = in_beat;
            skid_v_d = 1'b1;
          end
        end
        state == SKID && !stall: begin
          main_d   = skid_q;
          skid_d   = nop_beat;
          skid_v_d = 1'b0;
        end
        state == SKID && stall: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= nop_beat;
      main_v_q <= 1'b0;
      skid_q   <= nop_beat;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign id_valid = main_v_q;
  assign id_pc_4  = main_q.pc_4;
  assign id_instr = main_q.instr;

  assign opcode   = id_instr[31:26];
  assign rs       = id_instr[25:21];
  assign rt       = id_instr[20:16];
  assign rd       = id_instr[15:11];
  assign shamt    = id_instr[10:6];
  assign funct    = id_instr[5:0];
  assign imm      = id_instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  // Narrow PC paths keep only the low bits of the 28-bit region offset.
  generate
    if (PC_W > 28) begin : g_jt_wide
      assign jmp_target = {id_pc_4[PC_W-1:28], id_instr[25:0], 2'b00};
    end else begin : g_jt_narrow
      logic [27:0] tgt28;
      assign tgt28      = {id_instr[25:0], 2'b00};
      assign jmp_target = tgt28[PC_W-1:0];
    end
  endgenerate

endmodule
